// File: rtl/mem_port_arbiter_if.sv
// Requester, flush and memory-side signals of the data-memory port arbiter.
// The arbiter takes the slave modport; requesters and the memory take the master side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              last0, last1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              flush_req, flush_ack;
  logic [ADDR_W-1:0] mem_index;
  logic              mem_write;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_all;
  logic [DATA_W-1:0] mem_out;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, last0, last1,
           flush_req, mem_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, flush_ack,
           mem_index, mem_write, mem_write_data, mem_write_all, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, last0, last1,
           flush_req, mem_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, flush_ack,
           mem_index, mem_write, mem_write_data, mem_write_all, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner arbiter for the single-port data memory: grants bursts to one
// of two requesters, returns registered read data, and issues one-cycle result dumps.
module mem_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, FLUSH} state_e;

  state_e                 state_q, state_d;
  logic                   last_srv_q, last_srv_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [1:0]             rvalid_q;
  logic [DATA_W-1:0]      rdata_q;

  logic [1:0]             req, we, last, gnt, beat, rd_beat;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic                   enter_flush, flush_st;
  logic [ADDR_W-1:0]      mem_index;
  logic                   mem_write;
  logic [DATA_W-1:0]      mem_wdata;

  assign req   = {bus.req1, bus.req0};
  assign we    = {bus.we1, bus.we0};
  assign last  = {bus.last1, bus.last0};
  assign addr  = {bus.addr1, bus.addr0};
  assign wdata = {bus.wdata1, bus.wdata0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_srv_q   <= 1'b1;
      flush_pend_q <= 1'b0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_srv_q   <= last_srv_d;
      flush_pend_q <= flush_pend_d;
      rvalid_q     <= rd_beat;
      if (|rd_beat) rdata_q <= bus.mem_out;
    end
  end

  // A pending dump always beats waiting requesters; ties go to whoever was not served last.
  always_comb begin
    state_d     = state_q;
    last_srv_d  = last_srv_q;
    enter_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          state_d     = FLUSH;
          enter_flush = 1'b1;
        end else if (&req) state_d = last_srv_q ? OWN0 : OWN1;
        else if (req[0])   state_d = OWN0;
        else if (req[1])   state_d = OWN1;
      end
      OWN0: if (!req[0] || last[0]) begin
        state_d    = IDLE;
        last_srv_d = 1'b0;
      end
      OWN1: if (!req[1] || last[1]) begin
        state_d    = IDLE;
        last_srv_d = 1'b1;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Pulses arriving while a dump is already pending fold into that dump.
    flush_pend_d = (flush_pend_q | bus.flush_req) & ~enter_flush;
  end

  always_comb begin
    gnt      = '0;
    flush_st = 1'b0;
    case (state_q)
      OWN0:    gnt[0]   = 1'b1;
      OWN1:    gnt[1]   = 1'b1;
      FLUSH:   flush_st = 1'b1;
      default: ;
    endcase
    beat      = gnt & req;
    rd_beat   = beat & ~we;
    mem_index = '0;
    mem_write = 1'b0;
    mem_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      if (beat[i]) begin
        mem_index = addr[i];
        mem_write = we[i];
        mem_wdata = wdata[i];
      end
    end
  end

  assign bus.gnt0           = gnt[0];
  assign bus.gnt1           = gnt[1];
  assign bus.rvalid0        = rvalid_q[0];
  assign bus.rvalid1        = rvalid_q[1];
  assign bus.rdata          = rdata_q;
  assign bus.flush_ack      = flush_st;
  assign bus.mem_write_all  = flush_st;
  assign bus.mem_index      = mem_index;
  assign bus.mem_write      = mem_write;
  assign bus.mem_write_data = mem_wdata;
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected read responses,
// an independent monitor pops them on every rvalid and watches dump pulses.
module tb_mem_port_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] mem [128];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (bus.mem_write)   mem[bus.mem_index] <= bus.mem_write_data;
    else if (pre_we)     mem[pre_addr] <= pre_data;
  end
  assign bus.mem_out = mem[bus.mem_index];

  int checks = 0, errors = 0, flush_cnt = 0;
  bit started = 1'b0;
  typedef struct { int id; logic [DW-1:0] data; } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_r;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [DW-1:0] d);
    rsp_t r;
    r.id = id; r.data = d;
    exp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int id, input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit l);
    if (id == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.last0 = l;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.last1 = l;
    end
  endtask

  function automatic logic gnt_of(input int id);
    return (id == 0) ? bus.gnt0 : bus.gnt1;
  endfunction

  function automatic logic rval_of(input int id);
    return (id == 0) ? bus.rvalid0 : bus.rvalid1;
  endfunction

  // n beats at base+i, write data step*(i+1); fmask bit i pulses flush_req during beat i.
  task automatic burst(input int id, input int n, input bit wr, input logic [AW-1:0] base,
                       input logic [DW-1:0] step, input int fmask);
    int waitc = 0;
    drive(id, 1'b1, wr, base, step, n == 1);
    tick();
    while (!gnt_of(id) && waitc < 16) begin tick(); waitc++; end
    chk("burst_grant", gnt_of(id), 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        tick();
        if (!wr) chk("read_latency", rval_of(id), 1);
        drive(id, 1'b1, wr, base + AW'(i), step * DW'(i + 1), i == n - 1);
      end
      bus.flush_req = fmask[i];
      #1;
      chk("beat_write", bus.mem_write, wr);
    end
    tick();
    bus.flush_req = 1'b0;
    if (!wr) chk("read_latency", rval_of(id), 1);
    chk("burst_release", gnt_of(id), 0);
    drive(id, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (bus.rvalid0 || bus.rvalid1) begin
        chk("rvalid_onehot", bus.rvalid0 & bus.rvalid1, 0);
        if (exp_q.size() == 0) chk("rvalid_unexpected", {bus.rvalid1, bus.rvalid0}, 0);
        else begin
          mon_r = exp_q.pop_front();
          chk("rsp_id", bus.rvalid1 ? 1 : 0, mon_r.id);
          chk("rsp_data", bus.rdata, mon_r.data);
        end
      end
      if (bus.mem_write_all || bus.flush_ack) begin
        flush_cnt++;
        chk("flush_ack_eq_write_all", bus.flush_ack, bus.mem_write_all);
        chk("write_all_no_write", bus.mem_write, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] rr_exp [8];

  initial begin
    drive(0, 0, 0, '0, '0, 0);
    drive(1, 0, 0, '0, '0, 0);
    bus.flush_req = 1'b0;

    // Reset with memory preload
    rst = 1'b1;
    pre_we = 1'b1; pre_addr = 7'd5; pre_data = 32'hDEADBEEF;
    tick();
    pre_addr = 7'd31; pre_data = 32'h31;
    tick();
    pre_we = 1'b0;
    tick();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_flush_ack", bus.flush_ack, 0);
    chk("rst_write_all", bus.mem_write_all, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    rst = 1'b0;
    started = 1'b1;

    // Single read of mem[5]
    push(0, 32'hDEADBEEF);
    drive(0, 1, 0, 7'd5, '0, 1);
    tick();
    chk("single_gnt0", bus.gnt0, 1);
    chk("single_gnt1", bus.gnt1, 0);
    chk("single_busy", bus.busy, 1);
    chk("single_index", bus.mem_index, 5);
    tick();
    chk("single_rvalid0", bus.rvalid0, 1);
    chk("single_rdata", bus.rdata, 32'hDEADBEEF);
    chk("single_gnt_drop", bus.gnt0, 0);
    drive(0, 0, 0, '0, '0, 0);

    // Burst write by requester 1, readback by requester 0
    burst(1, 3, 1'b1, 7'd10, 32'h11, 0);
    push(0, 32'h11); push(0, 32'h22); push(0, 32'h33);
    burst(0, 3, 1'b0, 7'd10, '0, 0);
    push(1, 32'h33);
    burst(1, 1, 1'b0, 7'd12, '0, 0);

    // Flush pulsed twice during a 4-beat write burst, requester 1 waiting
    push(1, 32'h22);
    drive(1, 1, 0, 7'd11, '0, 1);
    burst(0, 4, 1'b1, 7'd20, 32'hA0, 32'b0110);
    chk("flush_wait_ack", bus.flush_ack, 0);
    chk("flush_wait_gnt1", bus.gnt1, 0);
    tick();
    chk("flush_write_all", bus.mem_write_all, 1);
    chk("flush_ack", bus.flush_ack, 1);
    chk("flush_busy", bus.busy, 1);
    chk("flush_gnt1", bus.gnt1, 0);
    tick();
    chk("flush_ack_pulse", bus.flush_ack, 0);
    chk("flush_write_all_pulse", bus.mem_write_all, 0);
    chk("post_flush_idle_gnt1", bus.gnt1, 0);
    tick();
    chk("post_flush_gnt1", bus.gnt1, 1);
    tick();
    chk("post_flush_rvalid1", bus.rvalid1, 1);
    drive(1, 0, 0, '0, '0, 0);

    // Early release without last
    drive(0, 1, 1, 7'd30, 32'h5A, 0);
    tick();
    chk("early_gnt0", bus.gnt0, 1);
    tick();
    drive(0, 0, 1, 7'd31, 32'hBAD, 0);
    #1;
    chk("early_no_write", bus.mem_write, 0);
    chk("early_gnt_hold", bus.gnt0, 1);
    tick();
    chk("early_gnt_drop", bus.gnt0, 0);
    chk("early_idle", bus.busy, 0);
    push(0, 32'h5A); push(0, 32'h31);
    burst(0, 2, 1'b0, 7'd30, '0, 0);
    push(1, 32'h280);
    burst(1, 1, 1'b0, 7'd23, '0, 0);

    // Reset while requester 1 owns the port with a read in flight
    push(1, 32'h11);
    drive(1, 1, 0, 7'd10, '0, 0);
    tick();
    chk("rstb_gnt1", bus.gnt1, 1);
    tick();
    drive(1, 1, 0, 7'd11, '0, 0);
    chk("rstb_rvalid_beat0", bus.rvalid1, 1);
    rst = 1'b1;
    tick();
    drive(1, 0, 0, '0, '0, 0);
    rst = 1'b0;
    #1;
    chk("rstb_gnt0", bus.gnt0, 0);
    chk("rstb_gnt1", bus.gnt1, 0);
    chk("rstb_rvalid1", bus.rvalid1, 0);
    chk("rstb_rdata", bus.rdata, 0);
    chk("rstb_busy", bus.busy, 0);
    chk("rstb_flush_ack", bus.flush_ack, 0);
    chk("rstb_mem_write", bus.mem_write, 0);

    // Round-robin with both requesters holding single-beat reads
    rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    push(0, 32'hDEADBEEF); push(1, 32'h11); push(0, 32'hDEADBEEF); push(1, 32'h11);
    drive(0, 1, 0, 7'd5, '0, 1);
    drive(1, 1, 0, 7'd10, '0, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_gnt_%0d", i), {bus.gnt1, bus.gnt0}, rr_exp[i]);
    end
    drive(0, 0, 0, '0, '0, 0);
    drive(1, 0, 0, '0, '0, 0);

    tick(); tick(); tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("flush_count", flush_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter and sequencer for the single-port 128x32 data memory of the convolution core. It grants memory ownership to one requester at a time, such as the image/kernel loader and the result writer. Owners may hold the grant across multi-beat bursts. When the arbiter owns the memory it issues the write, index and write_all (result dump) controls, and it returns registered read data to the active owner.

## Interface
Parameters:
- ADDR_W, 7, memory index width
- DATA_W, 32, memory word width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0 / req1  input  1  requester wants memory, one beat per cycle while granted
- we0 / we1  input  1  beat is a write (1) or read (0)
- addr0 / addr1  input  ADDR_W  beat address
- wdata0 / wdata1  input  DATA_W  beat write data
- last0 / last1  input  1  current beat is the final beat of the burst
- gnt0 / gnt1  output  1  registered grant; at most one high
- rvalid0 / rvalid1  output  1  one-cycle pulse, read data for that requester valid on rdata
- rdata  output  DATA_W  registered read data (shared)
- flush_req  input  1  pulse requesting a result dump
- flush_ack  output  1  one-cycle pulse when the dump pulse has been issued
- mem_index  output  ADDR_W  to memory index
- mem_write  output  1  to memory write
- mem_write_data  output  DATA_W  to memory write_data
- mem_write_all  output  1  registered, to memory write_all
- mem_out  input  DATA_W  combinational memory read data
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, OWN0, OWN1, FLUSH. Reset state is IDLE.
- flush_pend is set by flush_req in any state. It is cleared when the FSM enters FLUSH.
- IDLE, in priority order:
  - flush_pend → FLUSH.
  - Only req0 → OWN0. Only req1 → OWN1.
  - Both requesters → the one not in last_srv. last_srv resets to 1, so req0 wins the first tie.
- OWNx:
  - gntx=1. A beat occurs in every cycle with reqx=1.
  - mem_index=addrx, mem_write=wex, mem_write_data=wdatax. These are combinational from state and the owner's inputs.
  - A beat with lastx=1, or a cycle with reqx=0, ends ownership. The FSM → IDLE, last_srv←x.
- Outside OWNx with reqx=1: mem_write=0, mem_index=0, mem_write_data=0.
- Read beat in cycle N: rdata←mem_out and rvalidx=1 in cycle N+1. rdata holds its value until the next read beat. Write beats produce no rvalid.
- FLUSH: lasts exactly one cycle. mem_write_all=1 and flush_ack=1 during that cycle, both registered. Then → IDLE. No memory access occurs in FLUSH.
- A flush_req arriving during a burst never preempts the burst. It is serviced at the next IDLE, before any pending request.
- Multiple flush_req pulses while pending collapse into one dump.

## Timing
- Reset values: gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, flush_ack=0, mem_write_all=0, busy=0, mem_write=0. State=IDLE, last_srv=1, flush_pend=0.
- rst during a burst takes effect at that edge. No further beats occur, and a pending rvalid is dropped.
- Grant latency: req asserted in cycle N while in IDLE → gnt in cycle N+1 → first beat in N+1.
- Every burst is followed by at least one IDLE cycle, so consecutive owners are separated by ≥1 cycle.
- Read latency: 1 cycle from beat to rvalid/rdata.
- Write commits at the rising edge that ends the beat cycle.
- mem_write_all is high for exactly one cycle per dump. It never coincides with mem_write=1.
- Simultaneous flush_pend and requests in IDLE: FLUSH wins. Requests are arbitrated in the cycle after FLUSH.

## Test plan
- Single read: preload mem[5]=0xDEADBEEF. req0, we0=0, addr0=5, last0=1 at cycle N → gnt0 in N+1. At N+2: rvalid0=1, rdata=0xDEADBEEF, gnt0=0.
- Burst write then readback by the other requester: req1 bursts writes 0x11,0x22,0x33 to addrs 10–12, last1 on the third beat. Then req0 reads 10–12 → rvalid0 pulses carry 0x11,0x22,0x33 in order, each 1 cycle after its beat.
- Round-robin: req0 and req1 held high with single-beat bursts (last=1 each beat) → grants alternate gnt0,gnt1,gnt0… starting with gnt0, each separated by one IDLE cycle.
- Flush during burst: flush_req pulsed mid-way through a 4-beat req0 burst → all 4 beats complete. Then mem_write_all=1 and flush_ack=1 for exactly one cycle. A concurrently pending req1 is granted in the following arbitration.
- Early release: req0 deasserted mid-burst without last0 → gnt0 drops the next cycle, and no write occurs in the req0=0 cycle.
- Reset mid-burst: rst asserted while gnt1=1 with a read in flight → next cycle all outputs at reset values, no rvalid1. After reset, simultaneous requests grant requester 0 first.
